// File: rtl/lvt_pkg.sv
// Shared definitions for the LVT RAM write front-end.
// Holds the default lane/width/depth values, the derived pointer and
// count widths, and a popcount helper for lane-valid vectors.
package lvt_pkg;

  localparam int NPORT  = 8;
  localparam int AW     = 11;
  localparam int DW     = 32;
  localparam int DEPTH  = 16;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int LANE_W = $clog2(NPORT) + 1;

  function automatic logic [LANE_W-1:0] popcount(input logic [NPORT-1:0] v);
    logic [LANE_W-1:0] n;
    n = '0;
    for (int i = 0; i < NPORT; i++) n = n + LANE_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/lvt_wr_group_sel.sv
// Issue-group selector: combinational.
// Given the NPORT oldest queued addresses (slot 0 = oldest) and the number
// of slots that may be issued (cand), returns g = the longest prefix of the
// slots whose addresses are pairwise distinct, capped at cand.
//   addr : NPORT candidate addresses, slot i at addr[i]
//   cand : issuable slots this cycle (0 when holding or empty)
//   g    : slots to issue
module lvt_wr_group_sel #(
  parameter int NPORT = 8,
  parameter int AW    = 11,
  parameter int LW    = $clog2(NPORT) + 1
) (
  input  logic [NPORT-1:0][AW-1:0] addr,
  input  logic [LW-1:0]            cand,
  output logic [LW-1:0]            g
);

  // eq_m[j][i] (i < j): slot j repeats an address held by an older slot i.
  logic [NPORT-1:0][NPORT-1:0] eq_m;
  logic [NPORT-1:0]            conflict;
  logic [LW-1:0]               lim;

  for (genvar j = 0; j < NPORT; j++) begin : g_row
    for (genvar i = 0; i < NPORT; i++) begin : g_col
      if (i < j) begin : g_cmp
        assign eq_m[j][i] = (addr[j] == addr[i]);
      end else begin : g_zero
        assign eq_m[j][i] = 1'b0;
      end
    end
    assign conflict[j] = |eq_m[j];
  end

  // The first conflicting slot j bounds the group: slots 0..j-1 are distinct.
  always_comb begin
    lim = LW'(NPORT);
    for (int j = NPORT - 1; j >= 0; j--)
      if (conflict[j]) lim = LW'(j);
    g = (cand < lim) ? cand : lim;
  end

endmodule

// File: rtl/lvt_write_dispatcher.sv
// Write-side front-end for the multi-write-port LVT RAM.
// Buffers up to NPORT write requests per cycle in an in-order DEPTH-entry
// queue and each cycle issues the longest address-distinct run of the
// oldest entries onto the RAM write ports, so per-address program order
// is preserved.
//   clk, rst         : clock, asynchronous active-low reset
//   in_valid/addr/data : request lanes (lane i at [i*W +: W])
//   in_ready         : a full NPORT-lane burst fits in the queue
//   hold             : suppress issue this cycle
//   w_enb/w_addr/w_din : registered RAM write ports, port 0 = oldest entry
//   busy             : queue non-empty or a write is being driven
module lvt_write_dispatcher #(
  parameter int NPORT = lvt_pkg::NPORT,
  parameter int AW    = lvt_pkg::AW,
  parameter int DW    = lvt_pkg::DW,
  parameter int DEPTH = lvt_pkg::DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NPORT-1:0]    in_valid,
  input  logic [NPORT*AW-1:0] in_addr,
  input  logic [NPORT*DW-1:0] in_data,
  output logic                in_ready,
  input  logic                hold,
  output logic [NPORT-1:0]    w_enb,
  output logic [NPORT*AW-1:0] w_addr,
  output logic [NPORT*DW-1:0] w_din,
  output logic                busy
);

  import lvt_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(NPORT) + 1;

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, free;

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];

  logic [NPORT-1:0][AW-1:0] in_addr_l, cand_addr, w_addr_q;
  logic [NPORT-1:0][DW-1:0] in_data_l, cand_data, w_din_q;
  logic [NPORT-1:0][LW-1:0] lane_off;
  logic [NPORT-1:0]         w_enb_q;
  logic [LW-1:0]            pushed, cand, g;
  logic                     push;

  assign in_addr_l = in_addr;
  assign in_data_l = in_data;

  // Ready depends on occupancy only, never on the incoming valids.
  assign free     = CW'(DEPTH) - count;
  assign in_ready = (free >= CW'(NPORT));
  assign push     = in_ready && (|in_valid);
  assign pushed   = push ? popcount(in_valid) : '0;

  // Compaction: each valid lane lands at wr_ptr + (valid lanes below it).
  always_comb begin
    lane_off[0] = '0;
    for (int i = 1; i < NPORT; i++)
      lane_off[i] = lane_off[i-1] + LW'(in_valid[i-1]);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NPORT; i++) begin
      if (push && in_valid[i]) begin
        mem_addr[wr_ptr + PW'(lane_off[i])] <= in_addr_l[i];
        mem_data[wr_ptr + PW'(lane_off[i])] <= in_data_l[i];
      end
    end
  end

  // Window of the NPORT oldest slots; slots past count are stale but are
  // excluded by cand.
  for (genvar i = 0; i < NPORT; i++) begin : g_cand
    assign cand_addr[i] = mem_addr[rd_ptr + PW'(i)];
    assign cand_data[i] = mem_data[rd_ptr + PW'(i)];
  end

  always_comb begin
    if (hold || count == '0)      cand = '0;
    else if (count >= CW'(NPORT)) cand = LW'(NPORT);
    else                          cand = LW'(count);
  end

  lvt_wr_group_sel #(.NPORT(NPORT), .AW(AW), .LW(LW)) u_sel (
    .addr (cand_addr),
    .cand (cand),
    .g    (g)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      w_enb_q  <= '0;
      w_addr_q <= '0;
      w_din_q  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(pushed);
      rd_ptr <= rd_ptr + PW'(g);
      count  <= count + CW'(pushed) - CW'(g);
      for (int i = 0; i < NPORT; i++) begin
        w_enb_q[i] <= (LW'(i) < g);
        // Idle ports keep their last address/data.
        if (LW'(i) < g) begin
          w_addr_q[i] <= cand_addr[i];
          w_din_q[i]  <= cand_data[i];
        end
      end
    end
  end

  assign w_enb  = w_enb_q;
  assign w_addr = w_addr_q;
  assign w_din  = w_din_q;
  assign busy   = (count != '0) || (|w_enb_q);

endmodule

// File: doc/lvt_write_dispatcher.md
Name: lvt_write_dispatcher

Overview:
- Front-end that drives the write side of the team's multi-write-port LVT RAM (8 write ports, 2 read ports).
- Accepts bursts of up to NPORT write requests per cycle from a client and buffers them in order in a DEPTH-entry queue.
- Each cycle it issues as many queued writes as possible onto the RAM write ports, never putting two writes to the same address in one cycle, so program order to each address is preserved.

Parameters:
- NPORT, 8, number of input lanes and number of RAM write ports.
- AW, 11, address width; matches the RAM address width (BLOCKSIZE+1).
- DW, 32, data width.
- DEPTH, 16, queue entries; must be a power of 2 and at least NPORT.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  NPORT  per-lane request valid.
- in_addr  in  NPORT*AW  per-lane address; lane i is bits [i*AW +: AW].
- in_data  in  NPORT*DW  per-lane data; lane i is bits [i*DW +: DW].
- in_ready  out  1  queue can take a full NPORT-lane burst.
- hold  in  1  when 1, nothing is issued this cycle.
- w_enb  out  NPORT  RAM write enables; bit i drives RAM port i+1.
- w_addr  out  NPORT*AW  RAM write addresses.
- w_din  out  NPORT*DW  RAM write data.
- busy  out  1  queue not empty, or any w_enb bit high.

Behaviour:
- Reset (rst=0, asynchronous):
  - rd_ptr, wr_ptr, count cleared to 0.
  - w_enb, w_addr, w_din cleared to 0.
  - in_ready=1 and busy=0 immediately.
  - Reset asserted mid-operation discards all queued and in-flight requests.
- in_ready is combinational from count only: in_ready = (DEPTH - count) >= NPORT. It never depends on in_valid.
- Push:
  - Happens when in_ready=1 and in_valid != 0.
  - Valid lanes are compacted in ascending lane order; lane order defines program order within a burst.
  - Entries are written at wr_ptr, wr_ptr+1, ...; wr_ptr advances by popcount(in_valid), modulo DEPTH.
  - Invalid lanes are skipped and take no entry.
  - When in_ready=0, inputs are ignored (no push, no error).
- Group select (combinational, uses count before this cycle's push):
  - cand = min(count, NPORT).
  - g = the largest k ≤ cand such that entries rd_ptr .. rd_ptr+k-1 (mod DEPTH) all have pairwise distinct addresses.
  - g = 0 if hold=1 or count=0; otherwise g ≥ 1.
- Issue (registered outputs):
  - At posedge, w_enb[i] <= (i < g).
  - w_addr lane i and w_din lane i <= entry rd_ptr+i when i < g; otherwise they hold their previous value.
  - Port 0 always carries the oldest entry.
  - rd_ptr advances by g, modulo DEPTH.
- Count update: count_next = count + pushed - g. Simultaneous push and issue is allowed.
  - count ≤ DEPTH always holds, because a push needs DEPTH - count ≥ NPORT.
- Latency:
  - A request pushed at edge N is first eligible in the cycle after edge N.
  - It appears on w_enb no earlier than after edge N+1.
  - Minimum is two edges from acceptance to a visible write enable.
- Each w_enb pulse lasts exactly one cycle per issued entry. No entry is issued twice and none is dropped.
- Pointers wrap modulo DEPTH with no bubble. Full is count==DEPTH; empty is count==0.

Decomposition:
- Shared package lvt_pkg:
  - defaults NPORT=8, AW=11, DW=32, DEPTH=16.
  - PTR_W = log2(DEPTH), CNT_W = log2(DEPTH)+1.
  - a popcount function for NPORT-bit vectors.
- One sub-module, lvt_wr_group_sel: purely combinational. Inputs are the NPORT candidate addresses and cand; output is g. Core logic is a triangular address-compare matrix plus a first-conflict priority encode.
- The top level holds the queue storage, pointers, count, push compaction and output registers.

Test Plan:
- Reset mid-burst: queue 10 entries with hold=1, pulse rst=0 → w_enb=0, in_ready=1, busy=0 immediately; after release with hold=0, no writes ever issue.
- Single write: in_valid=8'b0000_0100, lane 2 addr=5 data=0xA5 → two edges later w_enb=8'b0000_0001, w_addr lane0=5, w_din lane0=0xA5 for exactly one cycle; busy drops the following cycle.
- Full distinct burst: 8 lanes with addr 0..7 and data 0x10..0x17 → next issue cycle w_enb=8'hFF, port i gets addr i and data 0x10+i; count returns to 0.
- Conflict split: burst addrs {3,4,3,9,1,2,6,7} → first issue cycle w_enb=8'b0000_0011 (addr 3, 4); next cycle w_enb=8'b0011_1111 with addrs 3,9,1,2,6,7 in that order.
- Full and hold: hold=1, push two 8-lane bursts → count=16, in_ready=0; a third burst is ignored; release hold → two full 8-wide issue cycles in push order, then in_ready=1.
- Wrap and concurrency: with hold=0, push random 1–8-lane bursts on every in_ready cycle for 200 cycles with random addresses in 0..15, model the RAM → every accepted request is issued exactly once; per-address write order matches push order; no cycle has duplicate addresses among enabled ports; pointer wrap exercised at least 10 times.
